// File: rtl/data_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_unit
// Purpose  : Multi-cycle data memory stage. It handles byte, half and word
//            loads and stores with sign/zero extension, uses a fixed access
//            latency, and drives a busy/done handshake to the controller.
// Option   : DMEM_MISALIGN_TRAP_EN
//              defined   - misaligned half/word accesses are trapped
//              undefined - those accesses are forced aligned instead
// Revision : 1.0  initial release
// ============================================================================
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [3:0]       count;

  // Request fields are captured at acceptance so that input changes do not
  // disturb an access that is already in flight.
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic [31:0]      wdata_q;
  logic [1:0]       size_q;
  logic             sext_q;
  logic             write_q;
  logic             misal_q;

  logic [31:0]      mem [DEPTH_WORDS];

  logic             accept;
  logic             commit;
  logic             misal_now;
  logic [31:0]      word_rd;
  logic [7:0]       sel8;
  logic [15:0]      sel16;
  logic [31:0]      load_val;
  logic [31:0]      store_val;
  logic [3:0]       byte_en;

  // Address bits above the array index do not affect the access; the
  // addresses wrap modulo the array depth.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{1'b0, addr[31:IDX_W+2]};

  assign accept = (state == S_IDLE) && (mem_read || mem_write);
  assign commit = (state == S_ACCESS) && (count == 4'd0);

`ifdef DMEM_MISALIGN_TRAP_EN
  // Size 11 is handled as a word access, so size[1] marks a word access.
  assign misal_now = ((size == SZ_HALF) && addr[0]) ||
                     (size[1] && (addr[1:0] != 2'b00));
`else
  assign misal_now = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> ACCESS (LATENCY cycles) -> RESP -> IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_ACCESS;
      S_ACCESS: if (count == 4'd0) state_next = S_RESP;
      S_RESP:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the current state
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_RESP);
    misaligned = (state == S_RESP) && misal_q;
  end

  // Capture the request at acceptance and count down the access latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wdata_q <= 32'd0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      write_q <= 1'b0;
      misal_q <= 1'b0;
    end else if (accept) begin
      count   <= CNT_LOAD;
      idx_q   <= addr[IDX_W+1:2];
      lane_q  <= addr[1:0];
      wdata_q <= write_data;
      size_q  <= size;
      sext_q  <= sign_ext;
      write_q <= mem_write;          // write wins when both are requested
      misal_q <= misal_now;
    end else if ((state == S_ACCESS) && (count != 4'd0)) begin
      count   <= count - 4'd1;
    end
  end

  // Lane selection for loads, and lane replication with byte enables for
  // stores. Half accesses ignore addr[0] and word accesses ignore addr[1:0].
  always_comb begin
    word_rd   = mem[idx_q];
    sel8      = word_rd[{lane_q, 3'b000} +: 8];
    sel16     = lane_q[1] ? word_rd[31:16] : word_rd[15:0];
    load_val  = word_rd;
    store_val = wdata_q;
    byte_en   = 4'b1111;
    case (size_q)
      SZ_BYTE: begin
        load_val  = {{24{sext_q & sel8[7]}}, sel8};
        store_val = {4{wdata_q[7:0]}};
        byte_en   = 4'b0001 << lane_q;
      end
      SZ_HALF: begin
        load_val  = {{16{sext_q & sel16[15]}}, sel16};
        store_val = {2{wdata_q[15:0]}};
        byte_en   = lane_q[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load result register; it is updated only by a completing, non-trapped load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data <= 32'd0;
    end else if (commit && !write_q && !misal_q) begin
      read_data <= load_val;
    end
  end

  // Storage array, not reset. A reset before the commit edge forces the FSM
  // to IDLE, so the write is dropped.
  always_ff @(posedge clk) begin
    if (commit && write_q && !misal_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx_q][8*i +: 8] <= store_val[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Multi-cycle data memory stage of the single-cycle/multi-cycle MIPS datapath.
- Takes load/store requests from the execute stage (ALU address plus rt data). Its `read_data` output feeds the 32-bit 2:1 writeback mux, which selects memory data over the ALU result.
- Supports byte, half and word accesses with sign/zero extension, a fixed configurable access latency, and a busy/done handshake that stalls the datapath controller.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; word index = addr[log2(DEPTH_WORDS)+1:2], upper address bits ignored.
- LATENCY, 2, access cycles from request acceptance to `done` (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mem_read  input  1  load request; sampled only in IDLE.
- mem_write  input  1  store request; sampled only in IDLE.
- addr  input  32  byte address.
- write_data  input  32  store data; the low byte/half is used for sub-word stores.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = treated as word.
- sign_ext  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- read_data  output  32  load result; holds its value until the next load completes.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse when the access completes.
- misaligned  output  1  error flag pulsed with `done` (only driven under the optional feature).

Behaviour:
- Reset (async, rst_n = 0):
  - FSM goes to IDLE; read_data = 0, busy = 0, done = 0, misaligned = 0, counter = 0.
  - The array is not reset.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if mem_write or mem_read is high at the clock edge, latch addr, write_data, size, sign_ext and op (write wins if both are high). Load counter = LATENCY-1 and go to ACCESS.
  - ACCESS: counter decrements each cycle. When counter = 0 at the edge:
    - store: commit the write to the array;
    - load: register the extended read result into read_data;
    - then go to RESP.
  - RESP: done = 1 for exactly this cycle, then IDLE.
- Latency: request sampled at edge 0 gives done high in the cycle after edge LATENCY. busy is high from the cycle after edge 0 through the RESP cycle inclusive. Back-to-back issue is possible on the cycle after done.
- Requests while busy are ignored and not queued. Input changes during ACCESS do not affect the access in flight, because all fields are latched.
- mem_read and mem_write both high: executed as a store only; read_data unchanged.
- Byte lanes are little-endian; lane = addr[1:0].
  - Byte store writes only that lane.
  - Half store writes lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all four lanes.
- Load extension:
  - byte/half loads take the selected lane(s), then sign- or zero-extend per the latched sign_ext;
  - word loads are returned unmodified.
- Alignment (feature disabled): addr[0] is ignored for half accesses and addr[1:0] for word accesses (accesses forced aligned).
- Stores never modify read_data.
- Reset mid-access: the FSM returns to IDLE with no write committed if reset asserts before the commit edge; read_data returns to 0.
- Addresses beyond DEPTH_WORDS wrap modulo DEPTH_WORDS.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: the block checks alignment at acceptance. A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, is misaligned. Such an access:
  - still runs the full LATENCY;
  - suppresses the store;
  - leaves read_data unchanged;
  - asserts misaligned together with done for one cycle.
- Not defined: misaligned is tied to 0 and the forced-alignment rule above applies.

Test Plan:
- Word round trip: store 0xDEADBEEF to 0x10, then load word from 0x10 → read_data = 0xDEADBEEF. done is high exactly LATENCY cycles after each request edge; busy = 1 for LATENCY+1 cycles.
- Byte store and extension:
  - store byte 0x80 to 0x13 over a word holding 0x11223344 → word reads 0x80223344;
  - signed byte load at 0x13 → 0xFFFFFF80;
  - unsigned byte load → 0x00000080.
- Half access: store half 0xA5A5 to 0x22, then signed half load at 0x22 → 0xFFFFA5A5; word at 0x20 keeps its low half unchanged.
- Busy ignore and collision:
  - during an ACCESS, raise mem_write to 0x30 → no write occurs (0x30 still reads its prior value);
  - in IDLE, assert read and write together with data 0x1234 → treated as store only, read_data unchanged.
- Reset abort: issue a store of 0xCAFEF00D to 0x40 (prior value 0), assert rst_n = 0 one cycle later → busy = 0 and read_data = 0 immediately; a later load of 0x40 returns 0.
- With DMEM_MISALIGN_TRAP_EN, word store of 0x55555555 to 0x41 → misaligned and done pulse together, and the word at 0x40 is unchanged. Without the macro, the same store writes word 0x40.
